// File: rtl/matrix_collector_if.sv
// Handshake and data bundle between the skewed array output edge and the de-skewer.
interface matrix_collector_if #(
   parameter int N = 32,
   parameter int W = 16
);
   logic         start;
   logic         accum;
   logic         vec_valid;
   logic [W-1:0] vector_in  [0:N-1];
   logic [W-1:0] matrix_out [0:N-1][0:N-1];
   logic         busy;
   logic         done;

   modport master (
      output start, accum, vec_valid, vector_in,
      input  matrix_out, busy, done
   );

   modport slave (
      input  start, accum, vec_valid, vector_in,
      output matrix_out, busy, done
   );
endinterface

// File: rtl/matrix_collector.sv
// De-skews anti-diagonal vectors from the systolic array into a full NxN matrix.
// Optional accumulate mode is enabled by defining MATRIX_COLLECTOR_ACCUM_EN.
module matrix_collector #(
   parameter int N = 32,
   parameter int W = 16
) (
   input  logic            clk,
   input  logic            rst,
   matrix_collector_if.slave bus
);
   localparam int STEPS = 2 * N - 1;
   localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t       state;
   logic [SW-1:0] step;
   logic         busy_q;
   logic         done_q;
   logic [W-1:0] mat [0:N-1][0:N-1];

   // Lane i at step s targets column s-i; negative or too-large columns never match.
   function automatic logic lane_hit(input logic [SW-1:0] s, input int i, input int j);
      logic signed [31:0] d;
      d = $signed(32'(s)) - $signed(i);
      return d == $signed(j);
   endfunction

`ifdef MATRIX_COLLECTOR_ACCUM_EN
   logic accum_q;

   function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return a + b;
   endfunction
`else
   logic unused_accum;
   assign unused_accum = bus.accum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         step   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef MATRIX_COLLECTOR_ACCUM_EN
         accum_q <= 1'b0;
`endif
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               mat[i][j] <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= COLLECT;
                  step   <= '0;
                  busy_q <= 1'b1;
`ifdef MATRIX_COLLECTOR_ACCUM_EN
                  accum_q <= bus.accum;
`endif
               end
            end
            COLLECT: begin
               if (bus.vec_valid) begin
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++)
                        if (lane_hit(step, i, j)) begin
`ifdef MATRIX_COLLECTOR_ACCUM_EN
                           mat[i][j] <= accum_q ? wrap_add(mat[i][j], bus.vector_in[i])
                                                : bus.vector_in[i];
`else
                           mat[i][j] <= bus.vector_in[i];
`endif
                        end
                  // Final diagonal: hand off to DONE with outputs already flipped.
                  if (step == SW'(STEPS - 1)) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     step <= step + SW'(1);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.matrix_out = mat;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
endmodule

// File: tb/tb_matrix_collector.sv
// Randomized self-checking bench for matrix_collector against a matrix-level reference model.
module tb_matrix_collector;
   localparam int N     = 32;
   localparam int W     = 16;
   localparam int STEPS = 2 * N - 1;
   localparam int BUDGET = 2000;
`ifdef MATRIX_COLLECTOR_ACCUM_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   busy_cnt;
   int   done_cnt;

   logic [W-1:0] src  [0:N-1][0:N-1];
   logic [W-1:0] mref [0:N-1][0:N-1];

   matrix_collector_if #(.N(N), .W(W)) bus ();

   matrix_collector #(.N(N), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_matrix(input string tag);
      int nbad;
      nbad = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (bus.matrix_out[i][j] !== mref[i][j]) nbad++;
      check(tag, nbad, 0);
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            mref[i][j] = '0;
   endtask

   task automatic load_src(input int kind);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            case (kind)
               0:       src[i][j] = W'(i * 32 + j);
               1:       src[i][j] = 16'hFFFF;
               2:       src[i][j] = 16'h0001;
               default: src[i][j] = W'($urandom);
            endcase
   endtask

   task automatic drive_lanes(input int s, input bit fill_dead);
      for (int i = 0; i < N; i++) begin
         if (s - i >= 0 && s - i < N) bus.vector_in[i] = src[i][s - i];
         else                        bus.vector_in[i] = fill_dead ? 16'hDEAD : W'($urandom);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      clear_model();
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check_matrix({tag, "_zero"});
   endtask

   // mode: 0 contiguous, 1 alternating valid, 2 random stalls
   task automatic transfer(input string tag, input bit acc, input int mode, input bit fill_dead,
                           input bit poke, input int abort_at);
      int  s, it, busy0, done0, ndead;
      bit  v, aborted;
      busy0 = busy_cnt;
      done0 = done_cnt;
      bus.start = 1'b1;
      bus.accum = acc;
      bus.vec_valid = 1'b0;
      tick();
      bus.start = 1'b0;
      bus.accum = 1'b0;
      check({tag, "_busy_on"}, bus.busy, 1);
      s = 0;
      it = 0;
      aborted = 1'b0;
      while (s < STEPS && it < BUDGET) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (it % 2 == 0);
            default: v = ($urandom_range(3) != 0);
         endcase
         bus.vec_valid = v;
         bus.start = poke && (s == 10);
         drive_lanes(s, fill_dead);
         tick();
         if (v) s++;
         it++;
         if (abort_at >= 0 && s == abort_at) begin
            aborted = 1'b1;
            break;
         end
      end
      bus.vec_valid = 1'b0;
      bus.start = 1'b0;
      if (aborted) begin
         do_reset({tag, "_abort"});
         tick();
         check({tag, "_abort_nodone"}, done_cnt - done0, 0);
         return;
      end
      if (s < STEPS) begin
         check({tag, "_budget"}, s, STEPS);
         return;
      end
      check({tag, "_done"}, bus.done, 1);
      check({tag, "_busy_off"}, bus.busy, 0);
      check({tag, "_busy_cycles"}, busy_cnt - busy0, it);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            mref[i][j] = (ACC_EN && acc) ? W'(mref[i][j] + src[i][j]) : src[i][j];
      check_matrix({tag, "_matrix"});
      if (fill_dead) begin
         ndead = 0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               if (bus.matrix_out[i][j] === 16'hDEAD) ndead++;
         check({tag, "_no_dead"}, ndead, 0);
      end
      bus.start = poke;
      tick();
      bus.start = 1'b0;
      check({tag, "_done_pulse"}, bus.done, 0);
      check({tag, "_idle_busy"}, bus.busy, 0);
      tick();
      check({tag, "_still_idle"}, bus.busy, 0);
      check({tag, "_done_count"}, done_cnt - done0, 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      busy_cnt = 0;
      done_cnt = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.accum = 1'b0;
      bus.vec_valid = 1'b0;
      for (int i = 0; i < N; i++) bus.vector_in[i] = '0;
      tick();
      do_reset("init");

      // Random activity then reset
      load_src(3);
      bus.start = 1'b1;
      bus.accum = 1'($urandom);
      tick();
      bus.start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         bus.vec_valid = 1'($urandom);
         bus.start = 1'($urandom);
         drive_lanes(c, 1'b0);
         tick();
      end
      bus.vec_valid = 1'b0;
      bus.start = 1'b0;
      do_reset("rand_rst");

      load_src(0);
      transfer("contig", 1'b0, 0, 1'b1, 1'b0, -1);
      transfer("toggle", 1'b0, 1, 1'b0, 1'b0, -1);
      transfer("poke", 1'b0, 0, 1'b0, 1'b1, -1);
      transfer("abort", 1'b0, 0, 1'b0, 1'b0, 30);
      transfer("after_abort", 1'b0, 0, 1'b0, 1'b0, -1);

      // Reset wins over start
      rst = 1'b1;
      bus.start = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      check("rst_start_busy", bus.busy, 0);
      tick();
      check("rst_start_idle", bus.busy, 0);
      clear_model();
      check_matrix("rst_start_zero");

      load_src(0);
      transfer("acc_base", 1'b0, 0, 1'b0, 1'b0, -1);
      transfer("acc_add", 1'b1, 2, 1'b0, 1'b0, -1);
      load_src(1);
      transfer("acc_ffff", 1'b0, 0, 1'b0, 1'b0, -1);
      load_src(2);
      transfer("acc_wrap", 1'b1, 0, 1'b0, 1'b0, -1);

      for (int r = 0; r < 3; r++) begin
         load_src(3);
         transfer("random", 1'($urandom), 2, 1'b0, 1'($urandom), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/matrix_collector.md
# matrix_collector

Output-side de-skewer for the systolic matrix unit. It consumes one anti-diagonal vector per accepted cycle, as produced by the skewed array datapath, and reassembles the vectors into a full N×N result matrix. At accepted step `s`, lane `i` carries element `[i][s-i]`. The block sits between the array's output edge and the result register file, and it signals completion after all `2N-1` diagonals have been collected.

## Interface
Parameters:
- `N`, default 32: matrix dimension and vector lane count.
- `W`, default 16: element width in bits.

Ports:
- `clk`, input, 1 bit: single clock; all logic on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `start`, input, 1 bit: begin a collection; honoured only in IDLE.
- `accum`, input, 1 bit: accumulate-mode request, sampled with `start`; ignored unless `MATRIX_COLLECTOR_ACCUM_EN` is defined.
- `vec_valid`, input, 1 bit: `vector_in` holds the current diagonal.
- `vector_in[0:N-1]`, input, W bits each: diagonal lanes.
- `matrix_out[0:N-1][0:N-1]`, output, W bits each: assembled matrix, registered.
- `busy`, output, 1 bit: high while in COLLECT.
- `done`, output, 1 bit: one-cycle pulse when the matrix is complete.

## Operation
- The state machine has three states: IDLE, COLLECT and DONE.
- Step counter `step` is `ceil(log2(2N-1))` bits wide (6 bits for N=32) and holds 0..2N-2.
- **IDLE:**
  - `start`=1 → COLLECT. `step`←0. The accumulate flag is latched.
  - `vector_in` is not accepted in the `start` cycle.
- **COLLECT:**
  - `vec_valid`=0 stalls the block: no write and no step change.
  - `vec_valid`=1 accepts the vector. For every lane `i` with `0 ≤ step-i ≤ N-1`, `matrix_out[i][step-i]` is written from `vector_in[i]`.
  - Lanes outside that range are ignored, whatever their value.
  - After an accept, `step` increments.
  - An accept with `step`=2N-2 → DONE.
- **DONE:**
  - Lasts exactly one cycle with `done`=1, then → IDLE.
  - `start` is ignored in this cycle.
- `start` asserted in COLLECT or DONE is ignored. It does not restart the transfer.
- Elements are never cleared by `start`. Without accumulate, every element is overwritten exactly once per complete transfer.
- Index arithmetic `step-i` is evaluated signed, or guarded with `i ≤ step`. There is no wrap into valid columns.
- **Reset:** takes effect at any cycle, including mid-transfer.
  - State→IDLE, `step`←0, `busy`=0, `done`=0.
  - Every `matrix_out` element ←0.
  - The accumulate flag is cleared.

## Timing
- Writes are registered. An element accepted at edge k is visible on `matrix_out` after edge k.
- Final accept at edge k → `done`=1 and `busy`=0 during the cycle after edge k. The complete matrix is valid in that same cycle.
- Minimum transfer time is 1 `start` cycle plus 2N-1 accept cycles (63 for N=32), then the 1-cycle DONE.
- The earliest next `start` is the cycle after DONE.
- `busy` is high from the cycle after the `start` edge through the final-accept cycle. It stays high during stalls.
- Simultaneous `rst` and `start`: reset wins.
- Simultaneous `rst` and final accept: reset wins, and no `done` is produced.

## Configuration
- Macro: `MATRIX_COLLECTOR_ACCUM_EN`.
- **Defined:**
  - A transfer started with `accum`=1 writes `matrix_out[i][j] ← matrix_out[i][j] + vector_in[i]`, modulo 2^W with wrap-around and no saturation.
  - A transfer started with `accum`=0 overwrites.
  - This supports K-tiled accumulation across successive array passes.
- **Undefined:**
  - `accum` is ignored and every write overwrites.
  - No adder logic is synthesized.

## Test plan
- **Reset:** assert `rst` for 2 cycles after random activity → every `matrix_out` element is 0, and `busy`=0, `done`=0.
- **Contiguous transfer:** use `M[i][j]=i*32+j`. Drive `start`, then 63 consecutive valid diagonals with out-of-range lanes set to 16'hDEAD → `busy` high for 63 cycles, then `done` pulses for 1 cycle, `matrix_out==M`, and no element is 16'hDEAD.
- **Stalled transfer:** toggle `vec_valid` 1,0,1,0 → `done` arrives 125 cycles after the first accept cycle, and `matrix_out==M`.
- **Ignored start:** pulse `start` at step 10 of COLLECT and again in the DONE cycle → the transfer completes normally, and the block returns to IDLE with `busy`=0.
- **Reset mid-transfer:** assert `rst` after 30 accepts → all elements are 0 and `done` never pulses. A following full transfer of `M` then yields `matrix_out==M`.
- **`MATRIX_COLLECTOR_ACCUM_EN`:** transfer `M` with `accum`=0, then `M` with `accum`=1 → `matrix_out==2M`. Next, load all 16'hFFFF, then accumulate all 16'h0001 → all elements 0. Without the macro, the same sequence gives `matrix_out` equal to the last input.
